// File: rtl/integrate_dump.sv
// Decimating integrate-and-dump stage: sums DECIM Q15.16 products and emits one scaled result per block.
// Optional output saturation is enabled by defining INTEGRATE_DUMP_SAT_EN (default build wraps to 32 bits).
module integrate_dump #(
  parameter int DECIM = 8,
  parameter int SHIFT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  localparam int CNT_W = $clog2(DECIM);
  localparam int ACC_W = 32 + CNT_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DECIM - 1);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic        [CNT_W-1:0] cnt_q, cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic        [31:0]      out_data_q, out_data_d;
  logic                    busy_q, busy_d;

  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] scaled;
  logic        [31:0]      result;
  logic                    in_fire;
  logic                    out_fire;

  // The single output register may be reloaded in the same cycle it drains.
  assign in_ready = ~out_valid_q | out_ready;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid_q & out_ready;

  assign sum    = acc_q + $signed({{CNT_W{in_data[31]}}, in_data});
  assign scaled = sum >>> SHIFT;

`ifdef INTEGRATE_DUMP_SAT_EN
  localparam logic signed [ACC_W-1:0] MAX_Q = ACC_W'(64'sd2147483647);
  localparam logic signed [ACC_W-1:0] MIN_Q = ACC_W'(-64'sd2147483648);

  always_comb begin
    result = 32'(scaled);
    if (scaled > MAX_Q) begin
      result = 32'h7FFF_FFFF;
    end else if (scaled < MIN_Q) begin
      result = 32'h8000_0000;
    end
  end
`else
  assign result = 32'(scaled);
`endif

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (out_fire) begin
      out_valid_d = 1'b0;
    end
    if (in_fire) begin
      if (cnt_q == LAST_CNT) begin
        out_data_d  = result;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_integrate_dump.sv
// Bench for integrate_dump: a mean instance (DECIM=4, SHIFT=2) and a raw-sum instance (DECIM=4, SHIFT=0)
// share one input stream; results are compared against a block-sum reference model.
module tb_integrate_dump;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        in_ready2, out_valid2, busy2;
  logic [31:0] out_data2;
  logic        in_ready0, out_valid0, busy0;
  logic [31:0] out_data0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  integrate_dump #(.DECIM(4), .SHIFT(2)) u_mean (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .busy(busy2)
  );

  integrate_dump #(.DECIM(4), .SHIFT(0)) u_raw (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .busy(busy0)
  );

  // Reference: exact block sum, floor-shifted, then clamped or wrapped to 32 bits.
  function automatic logic [31:0] model(input longint sum, input int sh);
    longint sc;
    sc = sum >>> sh;
`ifdef INTEGRATE_DUMP_SAT_EN
    if (sc > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (sc < -64'sd2147483648) return 32'h8000_0000;
`endif
    return sc[31:0];
  endfunction

  function automatic longint sx(input logic [31:0] v);
    return longint'($signed(v));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 32'h1234_5678; out_ready = 1'b0;
    tick(); tick();
    n_tests++; if (out_valid2 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid2); end
    n_tests++; if (out_data2 !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 00000000", out_data2); end
    n_tests++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy2); end
    n_tests++; if (in_ready2 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready2); end
    rst = 1'b0; in_valid = 1'b0;
    tick();
    $display("[TB] reset: out_valid=%b busy=%b", out_valid2, busy2);
  endtask

  task automatic test_unity();
    out_ready = 1'b1;
    repeat (3) feed(32'h0001_0000);
    n_tests++; if (out_valid2 !== 1'b0) begin n_fail++; $display("FAIL unity_early_valid: got %b want 0", out_valid2); end
    n_tests++; if (busy2 !== 1'b1) begin n_fail++; $display("FAIL unity_busy: got %b want 1", busy2); end
    feed(32'h0001_0000);
    n_tests++; if (out_valid2 !== 1'b1) begin n_fail++; $display("FAIL unity_valid: got %b want 1", out_valid2); end
    n_tests++; if (out_data2 !== 32'h0001_0000) begin n_fail++; $display("FAIL unity_data: got %h want 00010000", out_data2); end
    n_tests++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL unity_busy_end: got %b want 0", busy2); end
    $display("[TB] unity: out=%h", out_data2);
    tick();
    n_tests++; if (out_valid2 !== 1'b0) begin n_fail++; $display("FAIL unity_drain: got %b want 0", out_valid2); end
    n_tests++; if (out_data2 !== 32'h0001_0000) begin n_fail++; $display("FAIL unity_hold_data: got %h want 00010000", out_data2); end
  endtask

  task automatic test_mixed();
    out_ready = 1'b1;
    feed(32'h0001_0000); feed(32'hFFFF_0000); feed(32'h0002_0000); feed(32'h0002_0000);
    n_tests++; if (out_valid2 !== 1'b1 || out_data2 !== 32'h0001_0000) begin n_fail++; $display("FAIL mixed_block1: got v=%b %h want v=1 00010000", out_valid2, out_data2); end
    $display("[TB] mixed block1: out=%h", out_data2);
    repeat (4) feed(32'hFFFF_8000);
    n_tests++; if (out_valid2 !== 1'b1 || out_data2 !== 32'hFFFF_8000) begin n_fail++; $display("FAIL mixed_block2: got v=%b %h want v=1 ffff8000", out_valid2, out_data2); end
    $display("[TB] mixed block2: out=%h", out_data2);
    tick();
  endtask

  task automatic test_saturation();
    logic [31:0] exp_pos, exp_neg;
`ifdef INTEGRATE_DUMP_SAT_EN
    exp_pos = 32'h7FFF_FFFF; exp_neg = 32'h8000_0000;
`else
    exp_pos = 32'h0000_0000; exp_neg = 32'h0000_0000;
`endif
    out_ready = 1'b1;
    repeat (4) feed(32'h4000_0000);
    n_tests++; if (out_data0 !== exp_pos) begin n_fail++; $display("FAIL sat_pos_raw: got %h want %h", out_data0, exp_pos); end
    n_tests++; if (out_data2 !== 32'h4000_0000) begin n_fail++; $display("FAIL sat_pos_mean: got %h want 40000000", out_data2); end
    $display("[TB] saturation pos: raw=%h mean=%h", out_data0, out_data2);
    repeat (4) feed(32'hC000_0000);
    n_tests++; if (out_data0 !== exp_neg) begin n_fail++; $display("FAIL sat_neg_raw: got %h want %h", out_data0, exp_neg); end
    n_tests++; if (out_data2 !== 32'hC000_0000) begin n_fail++; $display("FAIL sat_neg_mean: got %h want c0000000", out_data2); end
    $display("[TB] saturation neg: raw=%h mean=%h", out_data0, out_data2);
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    repeat (4) feed(32'h0001_0000);
    n_tests++; if (out_valid2 !== 1'b1 || in_ready2 !== 1'b0) begin n_fail++; $display("FAIL bp_hold_entry: got v=%b rdy=%b want v=1 rdy=0", out_valid2, in_ready2); end
    in_valid = 1'b1; in_data = 32'h0002_0000;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_tests++;
      if (in_ready2 !== 1'b0 || out_valid2 !== 1'b1 || out_data2 !== 32'h0001_0000 || busy2 !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_stall cycle %0d: got rdy=%b v=%b d=%h busy=%b want 0 1 00010000 0", i, in_ready2, out_valid2, out_data2, busy2);
      end
    end
    out_ready = 1'b1;
    #1;
    n_tests++; if (in_ready2 !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", in_ready2); end
    tick();
    n_tests++; if (out_valid2 !== 1'b0 || busy2 !== 1'b1) begin n_fail++; $display("FAIL bp_drain: got v=%b busy=%b want v=0 busy=1", out_valid2, busy2); end
    in_valid = 1'b0;
    repeat (3) feed(32'h0002_0000);
    n_tests++; if (out_valid2 !== 1'b1 || out_data2 !== 32'h0002_0000) begin n_fail++; $display("FAIL bp_resume: got v=%b %h want v=1 00020000", out_valid2, out_data2); end
    $display("[TB] backpressure resume: out=%h", out_data2);
    tick();
  endtask

  task automatic test_streaming();
    longint s;
    logic [31:0] e2, e0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int b = 0; b < 6; b++) begin
      s = 0;
      for (int k = 0; k < 4; k++) begin
        in_data = $urandom;
        s += sx(in_data);
        tick();
        if (k < 3) begin
          n_tests++; if (out_valid2 !== 1'b0) begin n_fail++; $display("FAIL stream_gap b%0d k%0d: got %b want 0", b, k, out_valid2); end
        end
      end
      e2 = model(s, 2); e0 = model(s, 0);
      n_tests++; if (out_valid2 !== 1'b1 || out_data2 !== e2) begin n_fail++; $display("FAIL stream_mean b%0d: got v=%b %h want v=1 %h", b, out_valid2, out_data2, e2); end
      n_tests++; if (out_valid0 !== 1'b1 || out_data0 !== e0) begin n_fail++; $display("FAIL stream_raw b%0d: got v=%b %h want v=1 %h", b, out_valid0, out_data0, e0); end
      $display("[TB] stream block %0d: mean=%h raw=%h", b, out_data2, out_data0);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_midblock();
    out_ready = 1'b1;
    feed(32'h0005_0000); feed(32'h0005_0000);
    n_tests++; if (busy2 !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b want 1", busy2); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++; if (out_valid2 !== 1'b0 || busy2 !== 1'b0 || out_data2 !== 32'h0) begin n_fail++; $display("FAIL midrst_state: got v=%b busy=%b d=%h want 0 0 00000000", out_valid2, busy2, out_data2); end
    repeat (4) feed(32'h0002_0000);
    n_tests++; if (out_valid2 !== 1'b1 || out_data2 !== 32'h0002_0000) begin n_fail++; $display("FAIL midrst_next: got v=%b %h want v=1 00020000", out_valid2, out_data2); end
    $display("[TB] reset mid-block: next out=%h", out_data2);
    tick();
  endtask

  task automatic test_random_handshake();
    logic [31:0] q2[$], q0[$], blk[$];
    logic [31:0] e2, e0;
    longint s;
    bit ifire, ofire;
    for (int c = 0; c < 400; c++) begin
      in_valid  = (c < 360) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data   = $urandom;
      out_ready = (c < 360) ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      n_tests++; if (out_valid2 !== (q2.size() != 0)) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b want %b", c, out_valid2, q2.size() != 0); end
      n_tests++; if (in_ready2 !== (!out_valid2 || out_ready)) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b want %b", c, in_ready2, !out_valid2 || out_ready); end
      ifire = in_valid && in_ready2;
      ofire = out_valid2 && out_ready;
      if (ofire && q2.size() != 0) begin
        e2 = q2.pop_front(); e0 = q0.pop_front();
        n_tests++; if (out_data2 !== e2 || out_data0 !== e0) begin n_fail++; $display("FAIL rnd_data c%0d: got %h/%h want %h/%h", c, out_data2, out_data0, e2, e0); end
        $display("[TB] random out c%0d: mean=%h raw=%h", c, out_data2, out_data0);
      end
      if (ifire) begin
        blk.push_back(in_data);
        if (blk.size() == 4) begin
          s = 0;
          foreach (blk[i]) s += sx(blk[i]);
          q2.push_back(model(s, 2));
          q0.push_back(model(s, 0));
          blk.delete();
        end
      end
      @(posedge clk);
      #1;
    end
    n_tests++; if (q2.size() != 0 || out_valid2 !== 1'b0) begin n_fail++; $display("FAIL rnd_leftover: got pending=%0d v=%b want 0 0", q2.size(), out_valid2); end
    n_tests++; if (busy2 !== (blk.size() != 0)) begin n_fail++; $display("FAIL rnd_busy: got %b want %b", busy2, blk.size() != 0); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_unity();
    test_mixed();
    test_saturation();
    test_backpressure();
    test_streaming();
    test_reset_midblock();
    test_random_handshake();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
